tla_cap_ctrl: RTL and testbench
===============================

# tla_cap_ctrl

Capture sequencer in the Gc_clk125 control domain; drives the control-side capture configuration, trigger and handshake ports of the single-channel TLA clock-crossing bridge. Each host start request runs one capture sequence: configure, settle, verify the window echo, trigger, await ready, close. The block reports completion status and the number of ADC overflow cycles seen during the capture. Abort and timeout are handled without stalling the bridge.

## Interface
- TOP0_0, 3, window-distance field width
- LDD0_0, 32, pulse/plus field width
- SETTLE, 16, settle cycles after config load (≥1)
- TRIG_LEN, 8, Gc_cap_trig high cycles (≥1)
- TMO_W, 24, timeout counter width
- Gc_clk125  in  1  control clock; sole clock
- Gc_rst  in  1  synchronous, active-high reset
- Hs_start  in  1  start request, sampled in IDLE only
- Hs_abort  in  1  abort request, level
- Hs_mode  in  1  capture mode
- Hs_wdis  in  TOP0_0  window distance
- Hs_plus  in  LDD0_0  pulse parameter
- Hs_timeout  in  TMO_W  per-wait timeout in cycles; 0 = no timeout
- Hs_busy  out  1  sequence in progress
- Hs_done  out  1  one-cycle completion pulse
- Hs_err  out  2  00 ok, 01 timeout, 10 aborted
- Hs_of_cnt  out  16  saturating overflow-cycle count of last capture
- Gc_adc_of  in  1  ADC overflow flag, already in the control domain
- Gc_cap_mode  out  1;  Gc_cap_wdis  out  TOP0_0;  Gc_cap_plus  out  LDD0_0  capture config
- Gc_com_wdis  out  TOP0_0;  Gc_com_plus  out  LDD0_0  common config, same values as cap config
- Gc_com_open  out  1;  Gc_com_close  out  1  one-cycle pulses
- Gc_wdis  in  TOP0_0  window-distance echo from far domain
- Gc_cap_trig  out  1  capture trigger
- Gc_capr_rdy  in  1  capture-ready from far domain (level)

## Operation
- States: IDLE, LOAD, SETTLE, ECHO, TRIG, WAIT, CLOSE.
- IDLE: Hs_start=1 → latch Hs_mode/wdis/plus/timeout; → LOAD.
- LOAD (1 cycle): config outputs take latched values; Gc_com_open=1; Hs_of_cnt cleared; Hs_err cleared → SETTLE.
- SETTLE: exactly SETTLE cycles → ECHO.
- ECHO: Gc_wdis == latched wdis → TRIG; timeout expiry → CLOSE with err=01.
- TRIG: Gc_cap_trig=1 for exactly TRIG_LEN cycles → WAIT.
- WAIT: rising edge of Gc_capr_rdy (registered prior value 0, current 1) → CLOSE with err=00; a level already high on entry does not complete; timeout → CLOSE with err=01.
- CLOSE (1 cycle): Gc_com_close=1, Hs_done=1 → IDLE.
- Timeout counter reloads with latched timeout on ECHO and WAIT entry; expiry = counter reaching 0 after decrement; latched 0 disables it.
- Hs_abort=1 in LOAD..WAIT → CLOSE with err=10, Gc_cap_trig drops immediately. Priority: abort > timeout > normal progression. Abort in IDLE or CLOSE ignored.
- Hs_start ignored outside IDLE. Config outputs hold last values after CLOSE.
- Overflow count: +1 per cycle with Gc_adc_of=1 in TRIG or WAIT; saturates at 16'hFFFF; held until next LOAD.

## Timing
- All outputs registered. Reset values: all 0; state IDLE.
- Reset mid-sequence: next cycle all outputs 0, IDLE, no done pulse.
- Start at cycle 0 → cycle 1 LOAD (busy=1, com_open=1, config valid) → cycles 2..SETTLE+1 SETTLE → ECHO at SETTLE+2.
- Echo match sampled at cycle n → Gc_cap_trig high n+1..n+TRIG_LEN.
- Ready edge sampled at cycle m → CLOSE at m+1 (done=1, com_close=1, busy=1) → busy=0 at m+2; Hs_start at m+2 accepted.
- Minimum sequence, echo immediate and ready first WAIT cycle: done at cycle SETTLE+TRIG_LEN+4.
- Hs_err valid from the done cycle until next LOAD.

## Test plan
- Nominal: defaults, wdis=5, plus=32'hA5A5_0001, echo immediate, ready rises 10 cycles after trig ends → trig high 8 cycles, done at cycle 36, err=00, com_open at 1, com_close at 36.
- Echo timeout: timeout=100, Gc_wdis stuck 0 with wdis=3 → no trig, done 101 cycles after ECHO entry, err=01.
- Stale ready: Gc_capr_rdy high before start, held high → never completes; drop then raise in WAIT → done next cycle, err=00.
- Abort in TRIG cycle 3 with simultaneous timeout expiry elsewhere → trig low next cycle, CLOSE, err=10.
- Overflow: Gc_adc_of high 20 cycles inside TRIG/WAIT and 5 in SETTLE → Hs_of_cnt=20; 70000 cycles high → 16'hFFFF.
- Reset in WAIT → all outputs 0 next cycle, no done; new start runs nominally; start during busy ignored.

Source files
------------

// File: rtl/tla_cap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tla_cap_ctrl
// Description : Control-domain capture sequencer for the TLA clock-crossing
//               bridge (configure, settle, echo check, trigger, await, close).
// Revision    : 1.0 - initial release
// ============================================================================
module tla_cap_ctrl #(
    parameter int TOP0_0   = 3,
    parameter int LDD0_0   = 32,
    parameter int SETTLE   = 16,
    parameter int TRIG_LEN = 8,
    parameter int TMO_W    = 24
) (
    input  logic              Gc_clk125,
    input  logic              Gc_rst,
    input  logic              Hs_start,
    input  logic              Hs_abort,
    input  logic              Hs_mode,
    input  logic [TOP0_0-1:0] Hs_wdis,
    input  logic [LDD0_0-1:0] Hs_plus,
    input  logic [TMO_W-1:0]  Hs_timeout,
    output logic              Hs_busy,
    output logic              Hs_done,
    output logic [1:0]        Hs_err,
    output logic [15:0]       Hs_of_cnt,
    input  logic              Gc_adc_of,
    output logic              Gc_cap_mode,
    output logic [TOP0_0-1:0] Gc_cap_wdis,
    output logic [LDD0_0-1:0] Gc_cap_plus,
    output logic [TOP0_0-1:0] Gc_com_wdis,
    output logic [LDD0_0-1:0] Gc_com_plus,
    output logic              Gc_com_open,
    output logic              Gc_com_close,
    input  logic [TOP0_0-1:0] Gc_wdis,
    output logic              Gc_cap_trig,
    input  logic              Gc_capr_rdy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ECHO   = 3'd3;
    localparam logic [2:0] S_TRIG   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_CLOSE  = 3'd6;

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_tmo   = 2'b01;
    localparam logic [1:0] c_err_abort = 2'b10;

    localparam int PH_W = $clog2(((SETTLE > TRIG_LEN) ? SETTLE : TRIG_LEN) + 1);
    localparam logic [PH_W-1:0] c_settle_last = PH_W'(SETTLE - 1);
    localparam logic [PH_W-1:0] c_trig_last   = PH_W'(TRIG_LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [TMO_W-1:0]  tcnt_q, tcnt_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              rdy_q;
    logic              mode_q;
    logic [TOP0_0-1:0] wdis_q;
    logic [LDD0_0-1:0] plus_q;
    logic              busy_q, done_q, open_q, close_q, trig_q;
    logic [1:0]        err_q, err_d;
    logic [15:0]       of_q;
    logic              w_tmo_exp, w_rdy_rise, w_active;

    always_comb begin
        state_d    = state_q;
        err_d      = c_err_ok;
        ph_d       = (ph_q != '0) ? ph_q - 1'b1 : ph_q;
        tcnt_d     = (tcnt_q != '0) ? tcnt_q - 1'b1 : tcnt_q;
        w_tmo_exp  = (tmo_q != '0) && (tcnt_q == '0);
        w_rdy_rise = Gc_capr_rdy && !rdy_q;
        w_active   = (state_q != S_IDLE) && (state_q != S_CLOSE);

        case (state_q)
            S_IDLE:   if (Hs_start) state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (ph_q == '0) state_d = S_ECHO;
            S_ECHO: begin
                if (w_tmo_exp) begin
                    state_d = S_CLOSE;
                    err_d   = c_err_tmo;
                end else if (Gc_wdis == wdis_q) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG:   if (ph_q == '0) state_d = S_WAIT;
            S_WAIT: begin
                if (w_tmo_exp) begin
                    state_d = S_CLOSE;
                    err_d   = c_err_tmo;
                end else if (w_rdy_rise) begin
                    state_d = S_CLOSE;
                end
            end
            S_CLOSE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort overrides both timeout and normal progression in LOAD..WAIT.
        if (Hs_abort && w_active) begin
            state_d = S_CLOSE;
            err_d   = c_err_abort;
        end

        if (state_d != state_q) begin
            if (state_d == S_SETTLE) ph_d = c_settle_last;
            if (state_d == S_TRIG)   ph_d = c_trig_last;
            if ((state_d == S_ECHO) || (state_d == S_WAIT)) tcnt_d = tmo_q;
        end
    end

    always_ff @(posedge Gc_clk125) begin
        if (Gc_rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            tcnt_q  <= '0;
            tmo_q   <= '0;
            rdy_q   <= 1'b0;
            mode_q  <= 1'b0;
            wdis_q  <= '0;
            plus_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            open_q  <= 1'b0;
            close_q <= 1'b0;
            trig_q  <= 1'b0;
            err_q   <= 2'b00;
            of_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            tcnt_q  <= tcnt_d;
            rdy_q   <= Gc_capr_rdy;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_CLOSE);
            close_q <= (state_d == S_CLOSE);
            open_q  <= (state_d == S_LOAD);
            trig_q  <= (state_d == S_TRIG);

            if ((state_q == S_IDLE) && Hs_start) begin
                mode_q <= Hs_mode;
                wdis_q <= Hs_wdis;
                plus_q <= Hs_plus;
                tmo_q  <= Hs_timeout;
            end

            if (state_d == S_LOAD) begin
                err_q <= 2'b00;
            end else if ((state_d == S_CLOSE) && (state_q != S_CLOSE)) begin
                err_q <= err_d;
            end

            if (state_d == S_LOAD) begin
                of_q <= 16'h0000;
            end else if (((state_q == S_TRIG) || (state_q == S_WAIT)) &&
                         Gc_adc_of && (of_q != 16'hFFFF)) begin
                of_q <= of_q + 16'd1;
            end
        end
    end

    assign Hs_busy      = busy_q;
    assign Hs_done      = done_q;
    assign Hs_err       = err_q;
    assign Hs_of_cnt    = of_q;
    assign Gc_cap_mode  = mode_q;
    assign Gc_cap_wdis  = wdis_q;
    assign Gc_cap_plus  = plus_q;
    assign Gc_com_wdis  = wdis_q;
    assign Gc_com_plus  = plus_q;
    assign Gc_com_open  = open_q;
    assign Gc_com_close = close_q;
    assign Gc_cap_trig  = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_tla_cap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tla_cap_ctrl
// Description : Directed self-checking bench for the capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tla_cap_ctrl;
    localparam int TOP0_0 = 3, LDD0_0 = 32, SETTLE = 16, TRIG_LEN = 8, TMO_W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, mode, adc_of, rdy;
    logic [TOP0_0-1:0] wdis, gwdis, cap_wdis, com_wdis;
    logic [LDD0_0-1:0] plus, cap_plus, com_plus;
    logic [TMO_W-1:0]  tmo;
    logic busy, done, cap_mode, com_open, com_close, trig;
    logic [1:0]  err;
    logic [15:0] of_cnt;

    tla_cap_ctrl #(.TOP0_0(TOP0_0), .LDD0_0(LDD0_0), .SETTLE(SETTLE),
                   .TRIG_LEN(TRIG_LEN), .TMO_W(TMO_W)) dut (
        .Gc_clk125(clk), .Gc_rst(rst), .Hs_start(start), .Hs_abort(abort),
        .Hs_mode(mode), .Hs_wdis(wdis), .Hs_plus(plus), .Hs_timeout(tmo),
        .Hs_busy(busy), .Hs_done(done), .Hs_err(err), .Hs_of_cnt(of_cnt),
        .Gc_adc_of(adc_of), .Gc_cap_mode(cap_mode), .Gc_cap_wdis(cap_wdis),
        .Gc_cap_plus(cap_plus), .Gc_com_wdis(com_wdis), .Gc_com_plus(com_plus),
        .Gc_com_open(com_open), .Gc_com_close(com_close), .Gc_wdis(gwdis),
        .Gc_cap_trig(trig), .Gc_capr_rdy(rdy)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc, first_trig, last_trig, trig_n, done_cyc, done_n, close_cyc, open_n;

    // Cycle k is the interval after clock edge k; outputs are observed 1ns in.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (trig) begin
            if (first_trig < 0) first_trig = cyc;
            last_trig = cyc;
            trig_n++;
        end
        if (done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_n++;
        end
        if (com_close && close_cyc < 0) close_cyc = cyc;
        if (com_open) open_n++;
    endtask

    task automatic clr_mon();
        cyc = 0; first_trig = -1; last_trig = -1; trig_n = 0;
        done_cyc = -1; done_n = 0; close_cyc = -1; open_n = 0;
    endtask

    task automatic launch(input logic m, input logic [TOP0_0-1:0] w,
                          input logic [LDD0_0-1:0] p, input logic [TMO_W-1:0] t);
        mode = m; wdis = w; plus = p; tmo = t; start = 1'b1;
        clr_mon();
        step();
        start = 1'b0;
    endtask

    task automatic idle_gap();
        abort = 1'b0; adc_of = 1'b0; rdy = 1'b0; start = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; mode = 0; adc_of = 0; rdy = 0;
        wdis = 0; gwdis = 0; plus = 0; tmo = 0;
        clr_mon();
        repeat (3) step();
        n_cmp++;
        if ({busy, done, err, of_cnt, cap_mode, cap_wdis, cap_plus, com_wdis,
             com_plus, com_open, com_close, trig} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: busy=%b done=%b err=%b of=%h trig=%b want all 0",
                              busy, done, err, of_cnt, trig);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        gwdis = 3'd5;
        launch(1'b1, 3'd5, 32'hA5A5_0001, 24'd0);
        n_cmp++;
        if ({busy, com_open, cap_mode, cap_wdis, cap_plus, com_wdis, com_plus, of_cnt} !==
            {1'b1, 1'b1, 1'b1, 3'd5, 32'hA5A5_0001, 3'd5, 32'hA5A5_0001, 16'h0}) begin
            n_bad++; $display("FAIL nom_load: busy=%b open=%b wdis=%h plus=%h want 1 1 5 a5a50001",
                              busy, com_open, cap_wdis, cap_plus);
        end
        while (cyc < 37) begin
            rdy = (cyc >= 35);
            step();
        end
        n_cmp++;
        if ({first_trig, last_trig, trig_n} !== {32'sd19, 32'sd26, 32'sd8}) begin
            n_bad++; $display("FAIL nom_trig: first=%0d last=%0d n=%0d want 19 26 8",
                              first_trig, last_trig, trig_n);
        end
        n_cmp++;
        if ({done_cyc, close_cyc, done_n} !== {32'sd36, 32'sd36, 32'sd1}) begin
            n_bad++; $display("FAIL nom_done: done=%0d close=%0d n=%0d want 36 36 1",
                              done_cyc, close_cyc, done_n);
        end
        n_cmp++;
        if ({busy, err, cap_wdis, cap_plus, open_n} !== {1'b0, 2'b00, 3'd5, 32'hA5A5_0001, 32'sd1}) begin
            n_bad++; $display("FAIL nom_after: busy=%b err=%b wdis=%h opens=%0d want 0 00 5 1",
                              busy, err, cap_wdis, open_n);
        end
        idle_gap();
    endtask

    task automatic test_echo_timeout();
        gwdis = 3'd0;
        launch(1'b0, 3'd3, 32'h0000_0042, 24'd100);
        while (cyc < 125 && done_cyc < 0) step();
        n_cmp++;
        if ({done_cyc, trig_n, err} !== {32'sd119, 32'sd0, 2'b01}) begin
            n_bad++; $display("FAIL echo_timeout: done=%0d trig_n=%0d err=%b want 119 0 01",
                              done_cyc, trig_n, err);
        end
        idle_gap();
    endtask

    task automatic test_stale_ready();
        gwdis = 3'd4; rdy = 1'b1;
        step(); step();
        launch(1'b0, 3'd4, 32'h1, 24'd0);
        while (cyc < 60) step();
        n_cmp++;
        if ({done_n, busy} !== {32'sd0, 1'b1}) begin
            n_bad++; $display("FAIL stale_rdy_hold: done_n=%0d busy=%b want 0 1", done_n, busy);
        end
        rdy = 1'b0; step();
        rdy = 1'b1; step();
        n_cmp++;
        if ({done, cyc, err} !== {1'b1, 32'sd62, 2'b00}) begin
            n_bad++; $display("FAIL stale_rdy_edge: done=%b cyc=%0d err=%b want 1 62 00", done, cyc, err);
        end
        idle_gap();
    endtask

    task automatic test_abort();
        gwdis = 3'd5;
        launch(1'b0, 3'd5, 32'h2, 24'd0);
        while (cyc < 21) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({trig, done, com_close, err, trig_n} !== {1'b0, 1'b1, 1'b1, 2'b10, 32'sd3}) begin
            n_bad++; $display("FAIL abort_trig: trig=%b done=%b close=%b err=%b trig_n=%0d want 0 1 1 10 3",
                              trig, done, com_close, err, trig_n);
        end
        idle_gap();
        // Abort lands on the same cycle the echo timeout expires.
        gwdis = 3'd0;
        launch(1'b0, 3'd3, 32'h3, 24'd1);
        while (cyc < 19) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({done, err} !== {1'b1, 2'b10}) begin
            n_bad++; $display("FAIL abort_vs_tmo: done=%b err=%b want 1 10", done, err);
        end
        idle_gap();
        clr_mon();
        abort = 1'b1;
        repeat (3) step();
        abort = 1'b0;
        n_cmp++;
        if ({busy, done_n} !== {1'b0, 32'sd0}) begin
            n_bad++; $display("FAIL abort_idle: busy=%b done_n=%0d want 0 0", busy, done_n);
        end
        idle_gap();
    endtask

    task automatic test_overflow();
        gwdis = 3'd1;
        launch(1'b0, 3'd1, 32'h4, 24'd0);
        while (cyc < 50) begin
            adc_of = (cyc >= 5 && cyc <= 9) || (cyc >= 20 && cyc <= 39);
            rdy    = (cyc >= 45);
            step();
        end
        n_cmp++;
        if ({done_cyc, of_cnt} !== {32'sd46, 16'd20}) begin
            n_bad++; $display("FAIL of_count: done=%0d of=%0d want 46 20", done_cyc, of_cnt);
        end
        idle_gap();
    endtask

    task automatic test_of_saturate();
        gwdis = 3'd1;
        launch(1'b0, 3'd1, 32'h5, 24'd0);
        n_cmp++;
        if (of_cnt !== 16'd0) begin
            n_bad++; $display("FAIL of_clear: got %0d want 0", of_cnt);
        end
        while (cyc < 70030) begin
            adc_of = (cyc >= 19);
            rdy    = (cyc >= 70025);
            step();
            if (cyc == 119) begin
                n_cmp++;
                if (of_cnt !== 16'd100) begin
                    n_bad++; $display("FAIL of_mid: got %0d want 100", of_cnt);
                end
            end
        end
        n_cmp++;
        if ({done_cyc, of_cnt} !== {32'sd70026, 16'hFFFF}) begin
            n_bad++; $display("FAIL of_sat: done=%0d of=%h want 70026 ffff", done_cyc, of_cnt);
        end
        idle_gap();
    endtask

    task automatic test_back_to_back();
        gwdis = 3'd6;
        launch(1'b1, 3'd6, 32'h7, 24'd0);
        while (cyc < 30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, err, of_cnt, cap_mode, cap_wdis, cap_plus, com_wdis,
             com_plus, com_open, com_close, trig} !== '0) begin
            n_bad++; $display("FAIL rst_mid: busy=%b done=%b mode=%b wdis=%h want all 0",
                              busy, done, cap_mode, cap_wdis);
        end
        repeat (4) step();
        n_cmp++;
        if ({done_n, busy} !== {32'sd0, 1'b0}) begin
            n_bad++; $display("FAIL rst_no_done: done_n=%0d busy=%b want 0 0", done_n, busy);
        end
        gwdis = 3'd2;
        launch(1'b0, 3'd2, 32'h1234, 24'd0);
        while (cyc < 37) begin
            start = (cyc >= 5 && cyc <= 8);
            wdis  = start ? 3'd7 : 3'd2;
            rdy   = (cyc >= 35);
            step();
        end
        start = 1'b0; wdis = 3'd2;
        n_cmp++;
        if ({done_cyc, done_n, open_n, cap_wdis, busy} !== {32'sd36, 32'sd1, 32'sd1, 3'd2, 1'b0}) begin
            n_bad++; $display("FAIL b2b_ignore: done=%0d n=%0d opens=%0d wdis=%h busy=%b want 36 1 1 2 0",
                              done_cyc, done_n, open_n, cap_wdis, busy);
        end
        rdy = 1'b0;
        gwdis = 3'd3;
        launch(1'b1, 3'd3, 32'hBEEF, 24'd0);
        n_cmp++;
        if ({busy, com_open, cap_wdis} !== {1'b1, 1'b1, 3'd3}) begin
            n_bad++; $display("FAIL b2b_restart: busy=%b open=%b wdis=%h want 1 1 3", busy, com_open, cap_wdis);
        end
        abort = 1'b1;
        step();
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_echo_timeout();
        test_stale_ready();
        test_abort();
        test_overflow();
        test_of_saturate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
